// File: rtl/sdf_dif_stage_ctrl.sv
// Sequencer for one SDF DIF stage: fill/butterfly phasing, twiddle addressing,
// feedback/output mux control and end-of-batch self-drain of the feedback FIFO.
// Ports:
//   clk, rst (sync, active-low)
//   intt, in_valid, in_last -> in_ready
//   issue side:     btf_issue, tw_addr, tw_intt, fifo_en
//   writeback side: fifo_wr_sel, out_sel, out_valid, out_last
//   err (sticky)
module sdf_dif_stage_ctrl #(
  parameter int LOGN    = 8,
  parameter int STAGE   = 0,
  parameter int BTF_LAT = 7
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            intt,
  input  logic            in_valid,
  input  logic            in_last,
  output logic            in_ready,
  output logic            btf_issue,
  output logic [LOGN-2:0] tw_addr,
  output logic            tw_intt,
  output logic            fifo_en,
  output logic            fifo_wr_sel,
  output logic            out_sel,
  output logic            out_valid,
  output logic            out_last,
  output logic            err
);

  localparam int PB = LOGN - 1 - STAGE;
  localparam logic [LOGN-1:0] CNT_MAX = '1;
  localparam logic [LOGN-1:0] DMAX = LOGN'((1 << PB) - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [LOGN-1:0] r_cnt;
  logic [LOGN-1:0] r_dcnt;
  logic            r_primed;
  logic            r_err;
  logic            r_btf_issue;
  logic            r_fifo_en;
  logic [LOGN-2:0] r_tw_addr;
  logic            r_tw_intt;
  logic [BTF_LAT:0] r_v_sr;
  logic [BTF_LAT:0] r_p_sr;
  logic [BTF_LAT:0] r_l_sr;

  logic            w_accept;
  logic            w_slot;
  logic            w_dlast;
  logic            w_p;
  logic            w_end;
  logic            w_bad;
  logic            w_ev_v;
  logic [LOGN-2:0] w_tw;

  assign w_accept = in_valid & in_ready;
  assign w_slot   = (r_state == S_DRAIN);
  assign w_dlast  = w_slot & (r_dcnt == DMAX);
  assign w_p      = r_cnt[PB];
  assign w_end    = w_accept & in_last & (r_cnt == CNT_MAX);
  assign w_bad    = w_accept & in_last & (r_cnt != CNT_MAX);

  // (cnt mod D) << STAGE equals (cnt << STAGE) mod 2^(LOGN-1).
  assign w_tw = r_cnt[LOGN-2:0] << STAGE;

  // Drain slots are phase 0 and only occur once the stage is primed.
  assign w_ev_v = (w_accept & (w_p | r_primed)) | (w_slot & r_primed);

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE, S_RUN: begin
        if (w_accept) w_next = w_end ? S_DRAIN : S_RUN;
      end
      S_DRAIN: begin
        if (w_dlast) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_cnt       <= '0;
      r_dcnt      <= '0;
      r_primed    <= 1'b0;
      r_err       <= 1'b0;
      r_btf_issue <= 1'b0;
      r_fifo_en   <= 1'b0;
      r_tw_addr   <= '0;
      r_tw_intt   <= 1'b0;
      r_v_sr      <= '0;
      r_p_sr      <= '0;
      r_l_sr      <= '0;
    end else begin
      if (w_accept) r_cnt <= r_cnt + 1'b1;
      if (w_slot) r_dcnt <= w_dlast ? '0 : r_dcnt + 1'b1;
      if (w_dlast) begin
        r_primed <= 1'b0;
      end else if (w_accept & w_p) begin
        r_primed <= 1'b1;
      end
      if (w_bad) r_err <= 1'b1;
      r_btf_issue <= w_accept & w_p;
      r_fifo_en   <= w_accept | w_slot;
      if (w_accept) r_tw_addr <= w_tw;
      if (w_accept && r_cnt == '0) r_tw_intt <= intt;
      r_v_sr <= {r_v_sr[BTF_LAT-1:0], w_ev_v};
      r_p_sr <= {r_p_sr[BTF_LAT-1:0], w_accept & w_p};
      r_l_sr <= {r_l_sr[BTF_LAT-1:0], w_dlast};
    end
  end

  assign in_ready    = (r_state != S_DRAIN);
  assign btf_issue   = r_btf_issue;
  assign tw_addr     = r_tw_addr;
  assign tw_intt     = r_tw_intt;
  assign fifo_en     = r_fifo_en;
  assign fifo_wr_sel = r_p_sr[BTF_LAT];
  assign out_sel     = r_p_sr[BTF_LAT];
  assign out_valid   = r_v_sr[BTF_LAT];
  assign out_last    = r_l_sr[BTF_LAT];
  assign err         = r_err;

endmodule

// File: tb/tb_sdf_dif_stage_ctrl.sv
// Directed bench for sdf_dif_stage_ctrl at LOGN=4, STAGE=1 (D=4), BTF_LAT=3.
// Each scenario task drives vectors and compares against hand-computed values.
module tb_sdf_dif_stage_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       intt = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_last = 1'b0;
  logic       in_ready;
  logic       btf_issue;
  logic [2:0] tw_addr;
  logic       tw_intt;
  logic       fifo_en;
  logic       fifo_wr_sel;
  logic       out_sel;
  logic       out_valid;
  logic       out_last;
  logic       err;

  int checks = 0;
  int failures = 0;

  int e;
  int nov;
  int nsel;
  int nwr;
  int nlast;
  int nbusy;
  int nfe;
  int first_ov;
  int last16;

  sdf_dif_stage_ctrl #(
    .LOGN(4),
    .STAGE(1),
    .BTF_LAT(3)
  ) dut (
    .clk(clk),
    .rst(rst),
    .intt(intt),
    .in_valid(in_valid),
    .in_last(in_last),
    .in_ready(in_ready),
    .btf_issue(btf_issue),
    .tw_addr(tw_addr),
    .tw_intt(tw_intt),
    .fifo_en(fifo_en),
    .fifo_wr_sel(fifo_wr_sel),
    .out_sel(out_sel),
    .out_valid(out_valid),
    .out_last(out_last),
    .err(err)
  );

  always #5 clk = ~clk;

  task automatic clr();
    e = 0;
    nov = 0;
    nsel = 0;
    nwr = 0;
    nlast = 0;
    nbusy = 0;
    nfe = 0;
    first_ov = -1;
    last16 = 0;
  endtask

  task automatic step(input logic v, input logic l, input logic t);
    in_valid = v;
    in_last = l;
    intt = t;
    @(posedge clk);
    #1;
    if (out_valid) begin
      nov++;
      if (first_ov < 0) first_ov = e;
      if (out_sel) nsel++;
      if (fifo_wr_sel) nwr++;
      if (out_last && nov == 16) last16 = 1;
    end
    if (out_last) nlast++;
    if (!in_ready) nbusy++;
    if (fifo_en) nfe++;
    e++;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    in_valid = 1'b0;
    step(0, 0, 0);
    step(0, 0, 0);
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_in_ready got=%b want=1", in_ready);
    end
    checks++;
    if ({out_valid, btf_issue, err, fifo_en, out_last} !== 5'b0) begin
      failures++;
      $display("FAIL reset_outs got=%b want=00000",
               {out_valid, btf_issue, err, fifo_en, out_last});
    end
    checks++;
    if (tw_addr !== 3'd0) begin
      failures++;
      $display("FAIL reset_tw_addr got=%0d want=0", tw_addr);
    end
    rst = 1'b1;
  endtask

  task automatic test_single();
    logic       exp_b;
    logic [2:0] exp_a;
    clr();
    for (int k = 0; k < 16; k++) begin
      step(1, k == 15, 0);
      exp_b = ((k >> 2) & 1) == 1;
      checks++;
      if (btf_issue !== exp_b) begin
        failures++;
        $display("FAIL single_issue k=%0d got=%b want=%b", k, btf_issue, exp_b);
      end
      if (exp_b) begin
        exp_a = 3'((k % 4) * 2);
        checks++;
        if (tw_addr !== exp_a) begin
          failures++;
          $display("FAIL single_tw k=%0d got=%0d want=%0d", k, tw_addr, exp_a);
        end
      end
    end
    for (int i = 0; i < 15; i++) step(0, 0, 0);
    checks++;
    if (first_ov !== 7) begin
      failures++;
      $display("FAIL single_first_ov got=%0d want=7", first_ov);
    end
    checks++;
    if (nov !== 16) begin
      failures++;
      $display("FAIL single_ov_count got=%0d want=16", nov);
    end
    checks++;
    if (nbusy !== 4) begin
      failures++;
      $display("FAIL single_busy got=%0d want=4", nbusy);
    end
    checks++;
    if (nlast !== 1 || last16 !== 1) begin
      failures++;
      $display("FAIL single_last got=%0d/%0d want=1/1", nlast, last16);
    end
    checks++;
    if (nfe !== 20) begin
      failures++;
      $display("FAIL single_fifo_en got=%0d want=20", nfe);
    end
    checks++;
    if (nsel !== 8 || nwr !== 8) begin
      failures++;
      $display("FAIL single_sel got=%0d/%0d want=8/8", nsel, nwr);
    end
    checks++;
    if (err !== 1'b0 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL single_end got=%b%b want=01", err, in_ready);
    end
  endtask

  task automatic test_stall();
    clr();
    for (int k = 0; k < 6; k++) step(1, 0, 0);
    for (int i = 0; i < 2; i++) begin
      step(0, 0, 0);
      checks++;
      if (btf_issue !== 1'b0 || tw_addr !== 3'd2) begin
        failures++;
        $display("FAIL stall_gap i=%0d got=%b/%0d want=0/2", i, btf_issue, tw_addr);
      end
    end
    step(1, 0, 0);
    checks++;
    if (btf_issue !== 1'b1 || tw_addr !== 3'd4) begin
      failures++;
      $display("FAIL stall_resume got=%b/%0d want=1/4", btf_issue, tw_addr);
    end
    for (int k = 7; k < 16; k++) step(1, k == 15, 0);
    for (int i = 0; i < 15; i++) step(0, 0, 0);
    checks++;
    if (nov !== 16 || nlast !== 1) begin
      failures++;
      $display("FAIL stall_count got=%0d/%0d want=16/1", nov, nlast);
    end
  endtask

  task automatic test_back_to_back();
    clr();
    for (int k = 0; k < 16; k++) begin
      step(1, 0, 0);
      if (k == 0 || k == 15) begin
        checks++;
        if (tw_intt !== 1'b0) begin
          failures++;
          $display("FAIL b2b_intt0 k=%0d got=%b want=0", k, tw_intt);
        end
      end
    end
    for (int k = 0; k < 16; k++) begin
      step(1, k == 15, 1);
      if (k == 0) begin
        checks++;
        if (tw_intt !== 1'b1) begin
          failures++;
          $display("FAIL b2b_intt1 got=%b want=1", tw_intt);
        end
      end
    end
    checks++;
    if (nbusy !== 1) begin
      failures++;
      $display("FAIL b2b_no_gap got=%0d want=1", nbusy);
    end
    for (int i = 0; i < 15; i++) step(0, 0, 0);
    checks++;
    if (nov !== 32 || nlast !== 1) begin
      failures++;
      $display("FAIL b2b_count got=%0d/%0d want=32/1", nov, nlast);
    end
  endtask

  task automatic test_err();
    clr();
    for (int k = 0; k < 10; k++) step(1, k == 9, 0);
    checks++;
    if (err !== 1'b1 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL err_set got=%b%b want=11", err, in_ready);
    end
    step(1, 0, 0);
    checks++;
    if (tw_addr !== 3'd4 || btf_issue !== 1'b0) begin
      failures++;
      $display("FAIL err_k10 got=%0d/%b want=4/0", tw_addr, btf_issue);
    end
    step(1, 0, 0);
    checks++;
    if (tw_addr !== 3'd6) begin
      failures++;
      $display("FAIL err_k11 got=%0d want=6", tw_addr);
    end
    step(1, 0, 0);
    checks++;
    if (btf_issue !== 1'b1 || tw_addr !== 3'd0) begin
      failures++;
      $display("FAIL err_k12 got=%b/%0d want=1/0", btf_issue, tw_addr);
    end
    for (int k = 13; k < 16; k++) step(1, k == 15, 0);
    for (int i = 0; i < 10; i++) step(0, 0, 0);
    checks++;
    if (nbusy !== 4 || err !== 1'b1) begin
      failures++;
      $display("FAIL err_drain got=%0d/%b want=4/1", nbusy, err);
    end
  endtask

  task automatic test_reset_drain();
    rst = 1'b0;
    step(0, 0, 0);
    step(0, 0, 0);
    rst = 1'b1;
    checks++;
    if (err !== 1'b0) begin
      failures++;
      $display("FAIL rd_err_clear got=%b want=0", err);
    end
    clr();
    for (int k = 0; k < 16; k++) step(1, k == 15, 0);
    step(0, 0, 0);
    rst = 1'b0;
    step(0, 0, 0);
    rst = 1'b1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL rd_idle got=%b/%b want=1/0", in_ready, out_valid);
    end
    clr();
    for (int i = 0; i < 15; i++) step(0, 0, 0);
    checks++;
    if (nov !== 0 || nlast !== 0) begin
      failures++;
      $display("FAIL rd_quiet got=%0d/%0d want=0/0", nov, nlast);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_stall();
    test_back_to_back();
    test_err();
    test_reset_drain();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
